dot_operand_loader: RTL

//  Upstream feeder for matrix_dot. Packs a byte stream into 16x8-bit operand vectors a/b,

---
 rtl/npu_pkg.sv | 21 ++
 rtl/dot_operand_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU operand feeders.
package npu_pkg;

    localparam int N_ELEM = 16;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        RESULT = 3'd4,
        CLEAR  = 3'd5
    } loader_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dot_operand_loader.sv
// Packs a byte stream into a/b operand vectors for matrix_dot, runs one
// dot-product job, holds the result for the consumer, then clears the core.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  LOAD   | accept bytes; first N_ELEM -> a, next N_ELEM -> b
//  START  | hold dot_start high for START_HOLD cycles, operands frozen
//  WAIT   | wait for dot_done, abort with err_timeout after TIMEOUT_CYC
//  SETTLE | one cycle so dot_c is captured one cycle after done
//  RESULT | present out_data until the consumer accepts it
//  CLEAR  | hold dot_rst_n low for CLR_CYC cycles, then back to LOAD
module dot_operand_loader
    import npu_pkg::*;
#(
    parameter int N_ELEM      = npu_pkg::N_ELEM,
    parameter int ELEM_W      = npu_pkg::ELEM_W,
    parameter int ACC_W       = npu_pkg::ACC_W,
    parameter int START_HOLD  = 4,
    parameter int CLR_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEM_W-1:0]          in_data,
    output logic                       dot_start,
    output logic                       dot_rst_n,
    output logic [N_ELEM*ELEM_W-1:0]   dot_a,
    output logic [N_ELEM*ELEM_W-1:0]   dot_b,
    input  logic                       dot_done,
    input  logic [ACC_W-1:0]           dot_c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic                       err_timeout
);

    localparam int CNT_W = $clog2(2*N_ELEM);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int HC_W  = $clog2(max_int(START_HOLD, CLR_CYC) + 1);
    localparam int LAST  = 2*N_ELEM - 1;

    loader_state_t              r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [TMR_W-1:0]           r_tmr;
    logic [HC_W-1:0]            r_hold;
    logic [HC_W-1:0]            r_clr;
    logic [N_ELEM*ELEM_W-1:0]   r_dot_a;
    logic [N_ELEM*ELEM_W-1:0]   r_dot_b;
    logic                       r_in_ready;
    logic                       r_dot_start;
    logic                       r_dot_rst_n;
    logic                       r_out_valid;
    logic [ACC_W-1:0]           r_out_data;
    logic                       r_err;

    loader_state_t              w_state_nx;
    logic [CNT_W-1:0]           w_cnt_nx;
    logic [TMR_W-1:0]           w_tmr_nx;
    logic [HC_W-1:0]            w_hold_nx;
    logic [HC_W-1:0]            w_clr_nx;
    logic                       w_timeout;
    logic                       w_accept;
    logic                       w_is_b;
    logic [CNT_W-2:0]           w_elem;

    // in_ready is only ever high in LOAD after the clear window, so this
    // alone qualifies a byte write.
    assign w_accept = in_valid && r_in_ready;
    assign w_is_b   = r_cnt[CNT_W-1];
    assign w_elem   = r_cnt[CNT_W-2:0];

    // Next-state, counter and timeout-pulse decode.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tmr_nx   = r_tmr;
        w_hold_nx  = r_hold;
        w_clr_nx   = (r_clr != '0) ? r_clr - HC_W'(1) : '0;
        w_timeout  = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_accept) begin
                    if (r_cnt == CNT_W'(LAST)) begin
                        w_state_nx = START;
                        w_cnt_nx   = '0;
                        w_hold_nx  = HC_W'(START_HOLD);
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            START: begin
                if (r_hold <= HC_W'(1)) begin
                    w_state_nx = WAIT;
                    w_tmr_nx   = TMR_W'(TIMEOUT_CYC - 1);
                end else begin
                    w_hold_nx = r_hold - HC_W'(1);
                end
            end
            WAIT: begin
                // done has priority over a timeout landing on the same cycle
                if (dot_done) begin
                    w_state_nx = SETTLE;
                end else if (r_tmr == '0) begin
                    w_timeout  = 1'b1;
                    w_state_nx = CLEAR;
                    w_clr_nx   = HC_W'(CLR_CYC);
                end else begin
                    w_tmr_nx = r_tmr - TMR_W'(1);
                end
            end
            SETTLE: begin
                w_state_nx = RESULT;
            end
            RESULT: begin
                if (r_out_valid && out_ready) begin
                    w_state_nx = CLEAR;
                    w_clr_nx   = HC_W'(CLR_CYC);
                end
            end
            CLEAR: begin
                if (r_clr <= HC_W'(1)) begin
                    w_state_nx = LOAD;
                end
            end
            default: begin
                w_state_nx = LOAD;
            end
        endcase
    end

    // State and counters; reset starts with a core clear window in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_hold  <= '0;
            r_clr   <= HC_W'(CLR_CYC);
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_tmr   <= w_tmr_nx;
            r_hold  <= w_hold_nx;
            r_clr   <= w_clr_nx;
        end
    end

    // Operand capture; vectors keep their contents until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dot_a <= '0;
            r_dot_b <= '0;
        end else if (w_accept) begin
            if (!w_is_b) begin
                r_dot_a[w_elem*ELEM_W +: ELEM_W] <= in_data;
            end else begin
                r_dot_b[w_elem*ELEM_W +: ELEM_W] <= in_data;
            end
        end
    end

    // Registered control outputs, decoded from the next state so they line
    // up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_dot_start <= 1'b0;
            r_dot_rst_n <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nx == LOAD) && (w_clr_nx == '0);
            r_dot_start <= (w_state_nx == START);
            r_dot_rst_n <= (w_clr_nx == '0);
            r_err       <= w_timeout;
        end
    end

    // Result capture one cycle after done, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_state == SETTLE) begin
            r_out_valid <= 1'b1;
            r_out_data  <= dot_c;
        end else if ((r_state == RESULT) && r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign dot_start   = r_dot_start;
    assign dot_rst_n   = r_dot_rst_n;
    assign dot_a       = r_dot_a;
    assign dot_b       = r_dot_b;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign err_timeout = r_err;

endmodule
